// File: rtl/instruction_format_encoder.sv
// instruction_format_encoder
// Packs decoded instruction fields into a 32-bit instruction word. The layout
// depends on the selected format (D, DQ, DS, DX, MD, MDS). Each encoded word is
// held with its address in a 2-entry FIFO that feeds a valid/stall output port.
// All buses are numbered big-endian, so bit 0 is the MSB. A field narrower than
// its input bus is taken from the LSB end of that bus.
//
// Ports:
//   clock_i, resetn_i          clock, asynchronous active-low reset
//   enable_i / ready_o         input valid / input can be accepted
//   opCode_i, xOpCode_i        primary and extended opcodes
//   address_i                  address carried along with the word
//   instructionFormat_i        format code (D=3 DQ=4 DS=5 DX=6 MD=9 MDS=10)
//   reg1_i, reg2_i, reg3_i     register fields
//   imm_i, bit1_i, bit2_i      immediate and single-bit fields
//   stall_i                    downstream not ready
//   enable_o                   output valid (FIFO non-empty)
//   instruction_o, address_o   FIFO head
//   error_o                    one-cycle pulse when an accepted input is rejected
//
// Optional feature: define ENCODER_RANGE_CHECK_EN to reject an input whose imm_i
// or xOpCode_i bits lie above the field its format encodes and are non-zero.
// When the macro is undefined, those bits are dropped and the word is enqueued.
module instruction_format_encoder #(
    parameter int unsigned instructionWidth = 32,
    parameter int unsigned addressSize      = 64,
    parameter int unsigned formatIndexRange = 5,
    parameter int unsigned opcodeWidth      = 6,
    parameter int unsigned xOpCodeWidth     = 10,
    parameter int unsigned regWidth         = 5,
    parameter int unsigned immWidth         = 16,
    parameter int unsigned formatD          = 3,
    parameter int unsigned formatDQ         = 4,
    parameter int unsigned formatDS         = 5,
    parameter int unsigned formatDX         = 6,
    parameter int unsigned formatMD         = 9,
    parameter int unsigned formatMDS        = 10,
    parameter int unsigned formatInvalid    = 0
) (
    input  logic                          clock_i,
    input  logic                          resetn_i,
    input  logic                          enable_i,
    output logic                          ready_o,
    input  logic [0:opcodeWidth-1]        opCode_i,
    input  logic [0:xOpCodeWidth-1]       xOpCode_i,
    input  logic [0:addressSize-1]        address_i,
    input  logic [0:formatIndexRange-1]   instructionFormat_i,
    input  logic [0:regWidth-1]           reg1_i,
    input  logic [0:regWidth-1]           reg2_i,
    input  logic [0:regWidth-1]           reg3_i,
    input  logic [0:immWidth-1]           imm_i,
    input  logic                          bit1_i,
    input  logic                          bit2_i,
    input  logic                          stall_i,
    output logic                          enable_o,
    output logic [0:instructionWidth-1]   instruction_o,
    output logic [0:addressSize-1]        address_o,
    output logic                          error_o
);

    localparam logic [0:formatIndexRange-1] fmt_d       = formatIndexRange'(formatD);
    localparam logic [0:formatIndexRange-1] fmt_dq      = formatIndexRange'(formatDQ);
    localparam logic [0:formatIndexRange-1] fmt_ds      = formatIndexRange'(formatDS);
    localparam logic [0:formatIndexRange-1] fmt_dx      = formatIndexRange'(formatDX);
    localparam logic [0:formatIndexRange-1] fmt_md      = formatIndexRange'(formatMD);
    localparam logic [0:formatIndexRange-1] fmt_mds     = formatIndexRange'(formatMDS);
    localparam logic [0:formatIndexRange-1] fmt_invalid = formatIndexRange'(formatInvalid);

    logic [0:instructionWidth-1] word;
    logic                        fmt_ok;
    logic                        range_ok;
    logic                        accept;
    logic                        push;
    logic                        pop;

    logic [0:instructionWidth-1] mem_word [0:1];
    logic [0:addressSize-1]      mem_addr [0:1];
    logic                        wr_ptr;
    logic                        rd_ptr;
    logic [1:0]                  count;

    // Field packing for each format. Concatenation order runs from the MSB
    // (bit 0) down to bit 31.
    always_comb begin
        word     = '0;
        fmt_ok   = 1'b1;
        range_ok = 1'b1;
        case (instructionFormat_i)
            fmt_d: begin
                word = {opCode_i, reg1_i, reg2_i, imm_i};
            end
            fmt_ds: begin
                word = {opCode_i, reg1_i, reg2_i, imm_i[2:15], xOpCode_i[8:9]};
`ifdef ENCODER_RANGE_CHECK_EN
                range_ok = (imm_i[0:1] == '0) && (xOpCode_i[0:7] == '0);
`endif
            end
            fmt_dq: begin
                word = {opCode_i, reg1_i, reg3_i, imm_i[4:15], 4'b0000};
`ifdef ENCODER_RANGE_CHECK_EN
                range_ok = (imm_i[0:3] == '0);
`endif
            end
            fmt_dx: begin
                word = {opCode_i, reg1_i, imm_i[10:14], imm_i[0:9], xOpCode_i[5:9], imm_i[15]};
`ifdef ENCODER_RANGE_CHECK_EN
                range_ok = (xOpCode_i[0:4] == '0);
`endif
            end
            fmt_md: begin
                word = {opCode_i, reg1_i, reg2_i, reg3_i, imm_i[10:15], xOpCode_i[7:9], bit1_i, bit2_i};
`ifdef ENCODER_RANGE_CHECK_EN
                range_ok = (imm_i[0:9] == '0) && (xOpCode_i[0:6] == '0);
`endif
            end
            fmt_mds: begin
                word = {opCode_i, reg1_i, reg2_i, reg3_i, imm_i[10:15], xOpCode_i[6:9], bit1_i};
`ifdef ENCODER_RANGE_CHECK_EN
                range_ok = (imm_i[0:9] == '0) && (xOpCode_i[0:5] == '0);
`endif
            end
            fmt_invalid: fmt_ok = 1'b0;
            default:     fmt_ok = 1'b0;
        endcase
    end

`ifndef ENCODER_RANGE_CHECK_EN
    // No format encodes these xOpCode bits when range checking is off.
    logic unused_xop_bits;
    assign unused_xop_bits = |xOpCode_i[0:4];
`endif

    // Handshake. ready_o depends only on current occupancy, so a pop in the
    // same cycle cannot make a full FIFO accept a new input.
    assign ready_o = resetn_i && (count != 2'd2);
    assign accept  = enable_i && ready_o;
    assign push    = accept && fmt_ok && range_ok;
    assign pop     = enable_o && !stall_i;

    // FIFO head; gated so that an empty or reset FIFO presents zeros.
    assign enable_o      = (count != 2'd0);
    assign instruction_o = enable_o ? mem_word[rd_ptr] : '0;
    assign address_o     = enable_o ? mem_addr[rd_ptr] : '0;

    // FIFO storage, pointers (1-bit so they wrap modulo 2) and error pulse.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            mem_word[0] <= '0;
            mem_word[1] <= '0;
            mem_addr[0] <= '0;
            mem_addr[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            error_o     <= 1'b0;
        end else begin
            if (push) begin
                mem_word[wr_ptr] <= word;
                mem_addr[wr_ptr] <= address_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            error_o <= accept && !(fmt_ok && range_ok);
        end
    end

endmodule

// File: tb/tb_instruction_format_encoder.sv
// Scoreboard testbench for instruction_format_encoder. The driver pushes the
// expected {word, address} into exp_q when the DUT accepts an input. A negedge
// monitor compares the FIFO head, the valid/ready flags and the error pulse
// against that queue.
module tb_instruction_format_encoder;

    logic         clock_i = 1'b0;
    logic         resetn_i;
    logic         enable_i;
    logic         ready_o;
    logic [0:5]   opCode_i;
    logic [0:9]   xOpCode_i;
    logic [0:63]  address_i;
    logic [0:4]   instructionFormat_i;
    logic [0:4]   reg1_i;
    logic [0:4]   reg2_i;
    logic [0:4]   reg3_i;
    logic [0:15]  imm_i;
    logic         bit1_i;
    logic         bit2_i;
    logic         stall_i;
    logic         enable_o;
    logic [0:31]  instruction_o;
    logic [0:63]  address_o;
    logic         error_o;

    instruction_format_encoder dut (
        .clock_i             (clock_i),
        .resetn_i            (resetn_i),
        .enable_i            (enable_i),
        .ready_o             (ready_o),
        .opCode_i            (opCode_i),
        .xOpCode_i           (xOpCode_i),
        .address_i           (address_i),
        .instructionFormat_i (instructionFormat_i),
        .reg1_i              (reg1_i),
        .reg2_i              (reg2_i),
        .reg3_i              (reg3_i),
        .imm_i               (imm_i),
        .bit1_i              (bit1_i),
        .bit2_i              (bit2_i),
        .stall_i             (stall_i),
        .enable_o            (enable_o),
        .instruction_o       (instruction_o),
        .address_o           (address_o),
        .error_o             (error_o)
    );

    always #5 clock_i = ~clock_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [95:0] exp_q[$];        // {word[31:0], address[63:0]}
    bit          exp_err  = 1'b0; // error_o expected after the latest edge
    int          stall_hold = 0;
    bit          stall_rand = 1'b0;

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Reference encoder. It works on the conventional value of each field, where
    // big-endian bit k of the word is value bit 31-k.
    function automatic void model(input int unsigned op, x, fmt, r1, r2, r3, imm, b1, b2,
                                  output logic [31:0] w, output bit rej);
        int unsigned v = 0;
        bit range_bad  = 1'b0;
        rej = 1'b0;
        case (fmt)
            3: v = (op << 26) | (r1 << 21) | (r2 << 16) | imm;
            5: begin
                v = (op << 26) | (r1 << 21) | (r2 << 16) | ((imm & 32'h3FFF) << 2) | (x & 3);
                range_bad = ((imm >> 14) != 0) || ((x >> 2) != 0);
            end
            4: begin
                v = (op << 26) | (r1 << 21) | (r3 << 16) | ((imm & 32'hFFF) << 4);
                range_bad = ((imm >> 12) != 0);
            end
            6: begin
                v = (op << 26) | (r1 << 21) | (((imm >> 1) & 32'h1F) << 16) | ((imm >> 6) << 6)
                    | ((x & 32'h1F) << 1) | (imm & 1);
                range_bad = ((x >> 5) != 0);
            end
            9: begin
                v = (op << 26) | (r1 << 21) | (r2 << 16) | (r3 << 11) | ((imm & 32'h3F) << 5)
                    | ((x & 7) << 2) | (b1 << 1) | b2;
                range_bad = ((imm >> 6) != 0) || ((x >> 3) != 0);
            end
            10: begin
                v = (op << 26) | (r1 << 21) | (r2 << 16) | (r3 << 11) | ((imm & 32'h3F) << 5)
                    | ((x & 32'hF) << 1) | b1;
                range_bad = ((imm >> 6) != 0) || ((x >> 4) != 0);
            end
            default: rej = 1'b1;
        endcase
`ifdef ENCODER_RANGE_CHECK_EN
        if (range_bad) rej = 1'b1;
`else
        if (range_bad) v = v; // out-of-range bits are simply truncated
`endif
        w = 32'(v);
    endfunction

    task automatic drive_stall();
        if (stall_hold > 0) begin
            stall_i = 1'b1;
            stall_hold--;
        end else begin
            stall_i = stall_rand ? ($urandom_range(0, 9) < 3) : 1'b0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic idle(input int n);
        repeat (n) begin
            enable_i = 1'b0;
            @(posedge clock_i);
            exp_err = 1'b0;
            #1 drive_stall();
        end
    endtask

    // Present one input and hold it until it is accepted.
    task automatic send(input int unsigned op, x, fmt, r1, r2, r3, imm, b1, b2,
                        input logic [63:0] addr, input logic [31:0] exp_w, input bit rej,
                        output int waited);
        bit acc;
        bit done = 1'b0;
        waited = 0;
        enable_i            = 1'b1;
        opCode_i            = 6'(op);
        xOpCode_i           = 10'(x);
        instructionFormat_i = 5'(fmt);
        reg1_i              = 5'(r1);
        reg2_i              = 5'(r2);
        reg3_i              = 5'(r3);
        imm_i               = 16'(imm);
        bit1_i              = 1'(b1);
        bit2_i              = 1'(b2);
        address_i           = addr;
        while (!done) begin
            @(negedge clock_i);
            acc = ready_o;
            @(posedge clock_i);
            if (acc) begin
                exp_err = rej;
                if (!rej) exp_q.push_back({exp_w, addr});
                done = 1'b1;
            end else begin
                exp_err = 1'b0;
                waited++;
                if (waited > 60) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL accept_timeout: waited %0d cycles, required <= 60", waited);
                    done = 1'b1;
                end
            end
            #1 drive_stall();
        end
        enable_i = 1'b0;
    endtask

    task automatic send_model(input int unsigned op, x, fmt, r1, r2, r3, imm, b1, b2,
                              input logic [63:0] addr, output int waited);
        logic [31:0] w;
        bit          rej;
        model(op, x, fmt, r1, r2, r3, imm, b1, b2, w, rej);
        send(op, x, fmt, r1, r2, r3, imm, b1, b2, addr, w, rej, waited);
    endtask

    // Monitor: sample between edges and compare with the scoreboard.
    always @(negedge clock_i) begin
        if (resetn_i === 1'b1) begin
            check("enable_o", 64'(enable_o), 64'(exp_q.size() != 0));
            check("ready_o", 64'(ready_o), 64'(exp_q.size() < 2));
            check("error_o", 64'(error_o), 64'(exp_err));
            if (enable_o && exp_q.size() != 0) begin
                check("instruction_o", 64'(instruction_o), 64'(exp_q[0][95:64]));
                check("address_o", 64'(address_o), exp_q[0][63:0]);
                if (!stall_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          w;
        int unsigned fmt;
        int unsigned fmts[6] = '{3, 4, 5, 6, 9, 10};
        logic [31:0] exp31;
        bit          rej31;

        resetn_i = 1'b0; enable_i = 1'b0; stall_i = 1'b0;
        opCode_i = '0; xOpCode_i = '0; address_i = '0; instructionFormat_i = '0;
        reg1_i = '0; reg2_i = '0; reg3_i = '0; imm_i = '0; bit1_i = 1'b0; bit2_i = 1'b0;

        #12;
        check("reset_ready_o", 64'(ready_o), 64'd0);
        check("reset_enable_o", 64'(enable_o), 64'd0);
        check("reset_instruction_o", 64'(instruction_o), 64'd0);
        check("reset_address_o", 64'(address_o), 64'd0);
        check("reset_error_o", 64'(error_o), 64'd0);
        #5 resetn_i = 1'b1;
        @(posedge clock_i); #1;

        // D and DS reference encodings
        send(14, 0, 3, 3, 1, 0, 16'h0010, 0, 0, 64'h0000_0000_0000_1000, 32'h38610010, 1'b0, w);
        idle(2);
        send(58, 0, 5, 4, 1, 0, 16'h0002, 0, 0, 64'h0000_0000_0000_2004, 32'hE8810008, 1'b0, w);
        idle(2);
        // Invalid format: error pulse, nothing enqueued
        send(14, 0, 0, 3, 1, 0, 16'h0010, 0, 0, 64'hDEAD, 32'h0, 1'b1, w);
        idle(3);
        // DS with out-of-range immediate bits
        model(58, 0, 5, 4, 1, 0, 16'h4002, 0, 0, exp31, rej31);
        send(58, 0, 5, 4, 1, 0, 16'h4002, 0, 0, 64'h3000, 32'hE8810008, rej31, w);
        idle(3);

        // Three back-to-back inputs under stall: the third must wait
        stall_i = 1'b1; stall_hold = 5;
        send_model(1, 0, 3, 1, 2, 3, 16'h1111, 0, 0, 64'hA1, w);
        send_model(2, 3, 5, 4, 5, 6, 16'h2222, 0, 0, 64'hA2, w);
        send_model(3, 7, 9, 7, 8, 9, 16'h0033, 1, 0, 64'hA3, w);
        check("third_input_waited", 64'(w >= 3), 64'd1);
        idle(4);

        // Randomized traffic across all formats, with random stalls and gaps
        stall_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            fmt = ($urandom_range(0, 15) < 13) ? fmts[$urandom_range(0, 5)] : $urandom_range(0, 31);
            send_model($urandom_range(0, 63), $urandom_range(0, 1023), fmt,
                       $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                       ($urandom_range(0, 1) != 0) ? $urandom_range(0, 65535) : $urandom_range(0, 63),
                       $urandom_range(0, 1), $urandom_range(0, 1), {$urandom, $urandom}, w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        stall_rand = 1'b0;
        idle(6);

        // Reset while two entries are held
        stall_i = 1'b1; stall_hold = 10;
        send_model(5, 0, 3, 1, 1, 1, 16'h5555, 0, 0, 64'hB1, w);
        send_model(6, 0, 3, 2, 2, 2, 16'h6666, 0, 0, 64'hB2, w);
        check("held_before_reset", 64'(enable_o), 64'd1);
        #3 resetn_i = 1'b0;
        #1;
        check("midreset_enable_o", 64'(enable_o), 64'd0);
        check("midreset_instruction_o", 64'(instruction_o), 64'd0);
        check("midreset_address_o", 64'(address_o), 64'd0);
        check("midreset_ready_o", 64'(ready_o), 64'd0);
        exp_q.delete();
        exp_err = 1'b0;
        stall_hold = 0; stall_i = 1'b0;
        @(posedge clock_i); #2 resetn_i = 1'b1;
        @(posedge clock_i); #1;
        check("post_reset_enable_o", 64'(enable_o), 64'd0);
        idle(4);
        send_model(7, 0, 3, 3, 3, 3, 16'h7777, 0, 0, 64'hC1, w);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
